// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file write port.
// Clears all 16 registers after reset when INIT_ENABLE is set.
module regfile_write_arbiter #(
    parameter bit         INIT_ENABLE = 1'b1,
    parameter logic [3:0] INIT_VALUE  = 4'h0,
    parameter bit         ZERO_REG_RO = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req_valid,
    input  logic [3:0] req_addr0,
    input  logic [3:0] req_addr1,
    input  logic [3:0] req_addr2,
    input  logic [3:0] req_data0,
    input  logic [3:0] req_data1,
    input  logic [3:0] req_data2,
    output logic [2:0] req_ready,
    output logic       init_busy,
    output logic       rf_reg_write,
    output logic [3:0] rf_write_reg,
    output logic [3:0] rf_write_data,
    output logic [1:0] rf_src
);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    localparam state_t RST_STATE = INIT_ENABLE ? S_INIT : S_RUN;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [1:0] ptr;
    logic [2:0] grant;
    logic       xfer;
    logic [1:0] sel;
    logic [3:0] sel_addr;
    logic [3:0] sel_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == S_INIT && cnt == 4'd15) begin
            state_nxt = S_RUN;
        end
    end

    always_comb begin
        init_busy = (state == S_INIT);
        req_ready = (state == S_RUN) ? grant : 3'b000;
    end

    // Priority order is ptr, ptr+1, ptr+2 (mod 3)
    always_comb begin
        grant = 3'b000;
        unique case (ptr)
            2'd1: begin
                if (req_valid[1])      grant = 3'b010;
                else if (req_valid[2]) grant = 3'b100;
                else if (req_valid[0]) grant = 3'b001;
            end
            2'd2: begin
                if (req_valid[2])      grant = 3'b100;
                else if (req_valid[0]) grant = 3'b001;
                else if (req_valid[1]) grant = 3'b010;
            end
            default: begin
                if (req_valid[0])      grant = 3'b001;
                else if (req_valid[1]) grant = 3'b010;
                else if (req_valid[2]) grant = 3'b100;
            end
        endcase
    end

    always_comb begin
        xfer     = |req_ready;
        sel      = 2'd0;
        sel_addr = req_addr0;
        sel_data = req_data0;
        unique case (1'b1)
            req_ready[1]: begin
                sel      = 2'd1;
                sel_addr = req_addr1;
                sel_data = req_data1;
            end
            req_ready[2]: begin
                sel      = 2'd2;
                sel_addr = req_addr2;
                sel_data = req_data2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_reg_write  <= 1'b0;
            rf_write_reg  <= 4'd0;
            rf_write_data <= 4'd0;
            rf_src        <= 2'd0;
            cnt           <= 4'd0;
            ptr           <= 2'd0;
        end else if (state == S_INIT) begin
            rf_reg_write  <= 1'b1;
            rf_write_reg  <= cnt;
            rf_write_data <= INIT_VALUE;
            rf_src        <= 2'd3;
            cnt           <= cnt + 4'd1;
        end else if (xfer) begin
            rf_reg_write  <= !(ZERO_REG_RO && (sel_addr == 4'd0));
            rf_write_reg  <= sel_addr;
            rf_write_data <= sel_data;
            rf_src        <= sel;
            ptr           <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
        end else begin
            rf_reg_write  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter.
// Random requesters are checked against a queue-based reference model.
module tb_regfile_write_arbiter;

    localparam logic [3:0] INIT_VAL = 4'h0;
    localparam bit         ZRO      = 1'b1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] req_valid;
    logic [3:0] a [3];
    logic [3:0] d [3];
    logic [2:0] req_ready;
    logic       init_busy;
    logic       rf_reg_write;
    logic [3:0] rf_write_reg;
    logic [3:0] rf_write_data;
    logic [1:0] rf_src;

    logic       rst_b;
    logic [2:0] v_b;
    logic [3:0] ab [3];
    logic [3:0] db [3];
    logic [2:0] rdy_b;
    logic       busy_b;
    logic       we_b;
    logic [3:0] wr_b;
    logic [3:0] wd_b;
    logic [1:0] src_b;

    regfile_write_arbiter #(
        .INIT_ENABLE(1'b1),
        .INIT_VALUE (INIT_VAL),
        .ZERO_REG_RO(ZRO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_addr0    (a[0]),
        .req_addr1    (a[1]),
        .req_addr2    (a[2]),
        .req_data0    (d[0]),
        .req_data1    (d[1]),
        .req_data2    (d[2]),
        .req_ready    (req_ready),
        .init_busy    (init_busy),
        .rf_reg_write (rf_reg_write),
        .rf_write_reg (rf_write_reg),
        .rf_write_data(rf_write_data),
        .rf_src       (rf_src)
    );

    regfile_write_arbiter #(
        .INIT_ENABLE(1'b0),
        .INIT_VALUE (4'h5),
        .ZERO_REG_RO(1'b0)
    ) dut_b (
        .clk          (clk),
        .rst_n        (rst_b),
        .req_valid    (v_b),
        .req_addr0    (ab[0]),
        .req_addr1    (ab[1]),
        .req_addr2    (ab[2]),
        .req_data0    (db[0]),
        .req_data1    (db[1]),
        .req_data2    (db[2]),
        .req_ready    (rdy_b),
        .init_busy    (busy_b),
        .rf_reg_write (we_b),
        .rf_write_reg (wr_b),
        .rf_write_data(wd_b),
        .rf_src       (src_b)
    );

    typedef struct {
        bit we;
        int addr;
        int data;
        int src;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   m_cnt;
    int   m_ptr;
    int   last_grant;
    exp_t m_last;
    logic [3:0] rf [16];
    bit   busy_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Register file storage fed by the arbiter outputs
    always @(posedge clk) begin
        if (rf_reg_write === 1'b1) rf[rf_write_reg] <= rf_write_data;
    end

    always @(negedge clk) begin
        if (busy_b !== 1'b0) busy_seen = 1'b1;
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("rf_reg_write", rf_reg_write, e.we);
            check("rf_write_reg", rf_write_reg, e.addr);
            check("rf_write_data", rf_write_data, e.data);
            check("rf_src", rf_src, e.src);
        end
    end

    task automatic model_reset();
        m_cnt      = 0;
        m_ptr      = 0;
        last_grant = -1;
        m_last.we   = 1'b0;
        m_last.addr = 0;
        m_last.data = 0;
        m_last.src  = 0;
        q.delete();
    endtask

    // Called at a negedge with inputs set; predicts the coming edge.
    task automatic step();
        int         g;
        logic [2:0] exp_ready;
        exp_t       e;
        #1;
        g = -1;
        if (m_cnt < 16) begin
            check("init_busy_on", init_busy, 1);
            check("ready_in_init", req_ready, 0);
            e.we   = 1'b1;
            e.addr = m_cnt;
            e.data = INIT_VAL;
            e.src  = 3;
            m_cnt++;
        end else begin
            check("init_busy_off", init_busy, 0);
            for (int k = 0; k < 3; k++) begin
                int j;
                j = (m_ptr + k) % 3;
                if (g < 0 && req_valid[j]) g = j;
            end
            exp_ready = (g < 0) ? 3'b000 : 3'(1 << g);
            check("req_ready", req_ready, exp_ready);
            if (g >= 0) begin
                e.we   = (a[g] != 4'd0) || !ZRO;
                e.addr = a[g];
                e.data = d[g];
                e.src  = g;
                m_ptr  = (g + 1) % 3;
            end else begin
                e    = m_last;
                e.we = 1'b0;
            end
        end
        m_last = e;
        q.push_back(e);
        last_grant = g;
        @(negedge clk);
    endtask

    int seq [9] = '{0, 1, 2, 0, 1, 2, 0, 2, 0};
    bit did_reset = 1'b0;

    initial begin
        rst_n     = 1'b0;
        rst_b     = 1'b0;
        v_b       = 3'b000;
        req_valid = 3'b100;
        for (int i = 0; i < 3; i++) begin
            a[i]  = 4'd3;
            d[i]  = 4'd9;
            ab[i] = 4'd0;
            db[i] = 4'd0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_we", rf_reg_write, 0);
        check("rst_reg", rf_write_reg, 0);
        check("rst_data", rf_write_data, 0);
        check("rst_src", rf_src, 0);
        check("rst_busy", init_busy, 1);
        check("rst_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        while (m_cnt < 16) step();
        step();
        check("held_grant", last_grant, 2);

        a[0] = 4'd1;
        a[1] = 4'd2;
        a[2] = 4'd4;
        for (int i = 0; i < 9; i++) begin
            req_valid = (i >= 5) ? 3'b101 : 3'b111;
            step();
            check("rr_seq", last_grant, seq[i]);
        end

        req_valid = 3'b010;
        a[1]      = 4'd5;
        d[1]      = 4'hA;
        step();
        check("single_grant", last_grant, 1);
        req_valid = 3'b000;
        step();
        check("rf5_read", rf[5], 4'hA);

        req_valid = 3'b100;
        a[2]      = 4'd0;
        d[2]      = 4'hF;
        step();
        check("zero_grant", last_grant, 2);
        req_valid = 3'b000;
        step();
        check("rf0_kept", rf[0], INIT_VAL);

        for (int c = 0; c < 300; c++) begin
            if (c >= 150 && !did_reset && m_last.we) begin
                did_reset = 1'b1;
                rst_n     = 1'b0;
                #1;
                check("mid_rst_we", rf_reg_write, 0);
                check("mid_rst_reg", rf_write_reg, 0);
                check("mid_rst_data", rf_write_data, 0);
                check("mid_rst_src", rf_src, 0);
                check("mid_rst_busy", init_busy, 1);
                model_reset();
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
            for (int i = 0; i < 3; i++) begin
                if (!req_valid[i] || last_grant == i) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    a[i]         = 4'($urandom_range(0, 15));
                    d[i]         = 4'($urandom_range(0, 15));
                end
            end
            step();
        end
        check("mid_reset_done", did_reset, 1);
        req_valid = 3'b000;
        repeat (3) step();
        check("drain", q.size(), 0);
        check("rf0_final", rf[0], INIT_VAL);

        v_b   = 3'b001;
        ab[0] = 4'd7;
        db[0] = 4'd3;
        rst_b = 1'b1;
        #1;
        check("b_first_ready", rdy_b, 3'b001);
        check("b_busy", busy_b, 0);
        @(posedge clk);
        #1;
        check("b_we0", we_b, 1);
        check("b_reg0", wr_b, 7);
        check("b_data0", wd_b, 3);
        check("b_src0", src_b, 0);
        @(negedge clk);
        v_b   = 3'b100;
        ab[2] = 4'd0;
        db[2] = 4'hF;
        #1;
        check("b_ready2", rdy_b, 3'b100);
        @(posedge clk);
        #1;
        check("b_zero_we", we_b, 1);
        check("b_zero_reg", wr_b, 0);
        check("b_zero_data", wd_b, 4'hF);
        check("b_zero_src", src_b, 2);
        @(negedge clk);
        v_b = 3'b000;
        #1;
        check("b_idle_ready", rdy_b, 0);
        @(posedge clk);
        #1;
        check("b_idle_we", we_b, 0);
        check("b_hold_data", wd_b, 4'hF);
        check("b_hold_src", src_b, 2);
        check("b_busy_never", busy_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 4-bit register file among three writeback requesters (ALU writeback, load unit, debug/test port) using round-robin arbitration with a valid/ready handshake. Also sequences the register file after reset, writing a known value into all 16 registers, because the register file storage has no reset of its own. Sits between the writeback sources and the register file write port (reg_write / write_reg / write_data). Register file read ports are not touched.

## Interface
- INIT_ENABLE, 1: 1 = run the 16-cycle clear sequence after reset; 0 = go straight to arbitration.
- INIT_VALUE, 4'h0: data written to every register during the clear sequence.
- ZERO_REG_RO, 1: 1 = writes to address 0 are accepted but not performed (MIPS $zero).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  3  per-requester write request; bit i is requester i.
- req_addr0 / req_addr1 / req_addr2  in  4 each  target register for each requester.
- req_data0 / req_data1 / req_data2  in  4 each  write data for each requester.
- req_ready  out  3  one-hot grant; a transfer occurs on a rising edge where req_valid[i] && req_ready[i].
- init_busy  out  1  high while the clear sequence runs.
- rf_reg_write  out  1  drives register file reg_write; registered.
- rf_write_reg  out  4  drives register file write_reg; registered.
- rf_write_data  out  4  drives register file write_data; registered.
- rf_src  out  2  source of the current write: 0–2 = requester index, 3 = init sequencer; registered.

## Operation
- The FSM has two states:
  - INIT: entered on reset when INIT_ENABLE=1.
  - RUN: entered on reset when INIT_ENABLE=0, and after INIT completes.
- INIT behaviour:
  - A 4-bit counter cnt is reset to 0.
  - Each rising edge loads the outputs with {rf_reg_write=1, rf_write_reg=cnt, rf_write_data=INIT_VALUE, rf_src=3}, then increments cnt.
  - The edge that loads cnt=15 moves the FSM to RUN.
  - req_ready = 0 throughout INIT; requests wait.
  - ZERO_REG_RO does not apply; register 0 is also written.
- init_busy = (state==INIT). It is combinational from state.
- RUN arbitration:
  - A 2-bit pointer ptr (values 0–2, reset 0) sets priority order ptr, ptr+1, ptr+2 (mod 3).
  - The grant goes to the first requester in that order with req_valid set.
  - req_ready is a combinational decode of that grant. It may depend on req_valid.
  - req_valid must never depend on req_ready.
  - On a transfer from requester i, ptr ← (i+1) mod 3. With no transfer, ptr holds.
  - With no valid request, req_ready = 0.
- Requester rules: a requester holds valid, addr and data stable until accepted. Valid must not be dropped before acceptance.
- Output register on each rising edge in RUN:
  - Transfer from requester i: rf_reg_write ← !(ZERO_REG_RO && addr_i==0); rf_write_reg ← addr_i; rf_write_data ← data_i; rf_src ← i.
  - No transfer: rf_reg_write ← 0; rf_write_reg, rf_write_data and rf_src hold.
- Reset values: rf_reg_write=0, rf_write_reg=0, rf_write_data=0, rf_src=0, ptr=0, cnt=0. state=INIT if INIT_ENABLE, else RUN.
- Reset asserted mid-operation:
  - All state and outputs clear immediately (asynchronous).
  - A write held in the output register that has not yet reached the register file is discarded.
  - The clear sequence restarts from register 0 after rst_n rises.

## Timing
- Throughput: one accepted write per cycle, sustained.
- Latency:
  - Handshake edge N loads the output register.
  - rf_reg_write is high during cycle N+1.
  - The register file captures the write at edge N+1.
- Read-after-write visibility in the register file: available from edge N+1 on. The arbiter provides no bypass.
- INIT timing:
  - rf_reg_write is high for exactly 16 consecutive cycles, starting after the first rising edge following rst_n deassertion.
  - init_busy falls after the 16th edge.
  - req_ready can assert in the cycle immediately after.
- Simultaneous requests: exactly one grant per cycle. Losers see req_ready=0 and keep requesting.

## Test plan
- Reset and init, INIT_ENABLE=1, no requests:
  - rf_reg_write high for 16 cycles with rf_write_reg 0,1,…,15, data 4'h0, rf_src=3.
  - init_busy and req_ready=0 during the sequence; init_busy=0 afterwards.
  - A request held from reset is granted on the first RUN cycle.
- Single request: requester 1 presents addr 5, data 4'hA → req_ready=3'b010 the same cycle. Next cycle shows rf_reg_write=1, rf_write_reg=5, data=A, rf_src=1. A register file read of reg 5 afterwards returns A.
- Round-robin: all three valid continuously from ptr=0 → grants 0,1,2,0,1,2 on consecutive cycles. Requester 1 drops after its grant → sequence continues 2,0,2,0.
- Zero register: requester 2 writes addr 0, data 4'hF with ZERO_REG_RO=1 → handshake completes, rf_reg_write stays 0 and reg 0 stays 0. Same stimulus with ZERO_REG_RO=0 → written.
- Reset mid-stream: drop rst_n while rf_reg_write=1 → all outputs read 0 before the next edge. After release, the init sequence restarts at register 0 and ptr=0.
- INIT_ENABLE=0:
  - Requester 0 is valid when reset releases → req_ready[0]=1 in the first cycle after reset.
  - init_busy is never asserted.
